// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with a load-use hazard stall controller (RUN/STALL FSM).
// Define HAZARD_STATS_EN to add the bubble_count statistics port.
module id_ex_hazard_reg #(
  parameter int XLEN        = 32,
  parameter int CTRLW       = 8,
  parameter int LOAD_STALLS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_is_load,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [CTRLW-1:0] id_ctrl,
  input  logic             flush,
  output logic             stall_if_id,
  output logic             ex_valid,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_is_load,
  output logic [XLEN-1:0]  ex_rdata1,
  output logic [XLEN-1:0]  ex_rdata2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [CTRLW-1:0] ex_ctrl
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      bubble_count
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic             valid;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             is_load;
    logic [XLEN-1:0]  rdata1;
    logic [XLEN-1:0]  rdata2;
    logic [XLEN-1:0]  imm;
    logic [CTRLW-1:0] ctrl;
  } ex_slot_t;

  state_t   state, state_next;
  logic [1:0] cnt, cnt_next;
  ex_slot_t ex_q, ex_d;
  logic     hazard;
  logic     load_ex;
  logic     count_bubble;

  // A load still in EX cannot forward yet; x0 is hardwired and never conflicts.
  assign hazard = id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_q.rd)));

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    stall_if_id  = 1'b0;
    load_ex      = 1'b0;
    count_bubble = 1'b0;
    if (flush) begin
      state_next = RUN;
      cnt_next   = 2'd0;
    end else if (state == STALL) begin
      stall_if_id  = 1'b1;
      count_bubble = 1'b1;
      cnt_next     = cnt - 2'd1;
      if (cnt == 2'd1) state_next = RUN;
    end else if (hazard) begin
      stall_if_id  = 1'b1;
      count_bubble = 1'b1;
      if (LOAD_STALLS > 1) begin
        cnt_next   = 2'(LOAD_STALLS - 1);
        state_next = STALL;
      end
    end else begin
      load_ex = id_valid;
    end
  end

  // Anything not loaded from ID becomes a bubble with all fields zeroed.
  always_comb begin
    ex_d = '0;
    if (load_ex) begin
      ex_d.valid   = 1'b1;
      ex_d.rs1     = id_rs1;
      ex_d.rs2     = id_rs2;
      ex_d.rd      = id_rd;
      ex_d.is_load = id_is_load;
      ex_d.rdata1  = id_rdata1;
      ex_d.rdata2  = id_rdata2;
      ex_d.imm     = id_imm;
      ex_d.ctrl    = id_ctrl;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
      ex_q  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ex_q  <= ex_d;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             bubble_count <= 32'd0;
    else if (count_bubble) bubble_count <= bubble_count + 32'd1;
  end
`else
  logic unused_stats;
  assign unused_stats = count_bubble;
`endif

  assign ex_valid   = ex_q.valid;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_is_load = ex_q.is_load;
  assign ex_rdata1  = ex_q.rdata1;
  assign ex_rdata2  = ex_q.rdata2;
  assign ex_imm     = ex_q.imm;
  assign ex_ctrl    = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: two instances (LOAD_STALLS=1 and 3) share stimulus and
// are compared every cycle against a bubbles-remaining reference model.
module tb_id_ex_hazard_reg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [7:0]  ctrl;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_is_load, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic [7:0]  id_ctrl;

  logic        stall_a, stall_b;
  logic        ex_valid_a, ex_valid_b, ex_is_load_a, ex_is_load_b;
  logic [4:0]  ex_rs1_a, ex_rs1_b, ex_rs2_a, ex_rs2_b, ex_rd_a, ex_rd_b;
  logic [31:0] ex_rdata1_a, ex_rdata1_b, ex_rdata2_a, ex_rdata2_b, ex_imm_a, ex_imm_b;
  logic [7:0]  ex_ctrl_a, ex_ctrl_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] bc_a, bc_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.XLEN(32), .CTRLW(8), .LOAD_STALLS(1)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_is_load(id_is_load), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .stall_if_id(stall_a),
    .ex_valid(ex_valid_a), .ex_rs1(ex_rs1_a), .ex_rs2(ex_rs2_a), .ex_rd(ex_rd_a),
    .ex_is_load(ex_is_load_a), .ex_rdata1(ex_rdata1_a), .ex_rdata2(ex_rdata2_a),
    .ex_imm(ex_imm_a), .ex_ctrl(ex_ctrl_a)
`ifdef HAZARD_STATS_EN
    , .bubble_count(bc_a)
`endif
  );

  id_ex_hazard_reg #(.XLEN(32), .CTRLW(8), .LOAD_STALLS(3)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_is_load(id_is_load), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .stall_if_id(stall_b),
    .ex_valid(ex_valid_b), .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b), .ex_rd(ex_rd_b),
    .ex_is_load(ex_is_load_b), .ex_rdata1(ex_rdata1_b), .ex_rdata2(ex_rdata2_b),
    .ex_imm(ex_imm_b), .ex_ctrl(ex_ctrl_b)
`ifdef HAZARD_STATS_EN
    , .bubble_count(bc_b)
`endif
  );

  ex_t  act_ex [2];
  logic act_stall [2];
  assign act_ex[0] = {ex_valid_a, ex_rs1_a, ex_rs2_a, ex_rd_a, ex_is_load_a,
                      ex_rdata1_a, ex_rdata2_a, ex_imm_a, ex_ctrl_a};
  assign act_ex[1] = {ex_valid_b, ex_rs1_b, ex_rs2_b, ex_rd_b, ex_is_load_b,
                      ex_rdata1_b, ex_rdata2_b, ex_imm_b, ex_ctrl_b};
  assign act_stall[0] = stall_a;
  assign act_stall[1] = stall_b;

  // Reference model: EX contents, bubbles still owed, and bubbles counted so far.
  int          ls_of  [2] = '{1, 3};
  ex_t         m_ex   [2] = '{default: '0};
  int          m_left [2] = '{0, 0};
  logic [31:0] m_cnt  [2] = '{32'd0, 32'd0};

  function automatic logic m_hazard(input int k);
    ex_t e = m_ex[k];
    return id_valid && e.valid && e.is_load && (e.rd != 5'd0) &&
           ((id_uses_rs1 && id_rs1 == e.rd) || (id_uses_rs2 && id_rs2 == e.rd));
  endfunction

  function automatic logic exp_stall(input int k);
    return !reset && !flush && (m_left[k] > 0 || m_hazard(k));
  endfunction

  function automatic ex_t id_as_ex();
    return {1'b1, id_rs1, id_rs2, id_rd, id_is_load, id_rdata1, id_rdata2, id_imm, id_ctrl};
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_ex[k]   <= '0;
        m_left[k] <= 0;
        m_cnt[k]  <= 32'd0;
      end else if (flush) begin
        m_ex[k]   <= '0;
        m_left[k] <= 0;
      end else if (m_left[k] > 0) begin
        m_ex[k]   <= '0;
        m_left[k] <= m_left[k] - 1;
        m_cnt[k]  <= m_cnt[k] + 32'd1;
      end else if (m_hazard(k)) begin
        m_ex[k]   <= '0;
        m_left[k] <= ls_of[k] - 1;
        m_cnt[k]  <= m_cnt[k] + 32'd1;
      end else begin
        m_ex[k]   <= id_valid ? id_as_ex() : '0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall[%0d]", k), act_stall[k], exp_stall(k));
      check($sformatf("ex_valid[%0d]", k), act_ex[k].valid, m_ex[k].valid);
      check($sformatf("ex_rs1[%0d]", k), act_ex[k].rs1, m_ex[k].rs1);
      check($sformatf("ex_rs2[%0d]", k), act_ex[k].rs2, m_ex[k].rs2);
      check($sformatf("ex_rd[%0d]", k), act_ex[k].rd, m_ex[k].rd);
      check($sformatf("ex_is_load[%0d]", k), act_ex[k].is_load, m_ex[k].is_load);
      check($sformatf("ex_ctrl[%0d]", k), act_ex[k].ctrl, m_ex[k].ctrl);
      if (m_ex[k].valid) begin
        check($sformatf("ex_rdata1[%0d]", k), act_ex[k].d1, m_ex[k].d1);
        check($sformatf("ex_rdata2[%0d]", k), act_ex[k].d2, m_ex[k].d2);
        check($sformatf("ex_imm[%0d]", k), act_ex[k].imm, m_ex[k].imm);
      end
    end
`ifdef HAZARD_STATS_EN
    check("bubble_count[0]", bc_a, m_cnt[0]);
    check("bubble_count[1]", bc_b, m_cnt[1]);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic ld, input logic [31:0] imm);
    id_valid    = v;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_is_load  = ld;
    id_imm      = imm;
    id_rdata1   = $urandom;
    id_rdata2   = $urandom;
    id_ctrl     = 8'($urandom);
  endtask

  task automatic clear_pipe();
    flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (4) tick();
  endtask

  task automatic expect_ex_zero(input string tag);
    check({tag, " ex_valid"}, ex_valid_a | ex_valid_b, 1'b0);
    check({tag, " ex_regs"}, {ex_rs1_a, ex_rs2_a, ex_rd_a, ex_rs1_b, ex_rs2_b, ex_rd_b}, 30'd0);
    check({tag, " ex_data"}, ex_rdata1_a | ex_rdata2_a | ex_imm_a | ex_rdata1_b | ex_rdata2_b | ex_imm_b, 32'd0);
    check({tag, " ex_ctrl_load"}, {ex_ctrl_a, ex_ctrl_b, ex_is_load_a, ex_is_load_b}, 18'd0);
    check({tag, " stall"}, {stall_a, stall_b}, 2'b00);
  endtask

  logic [31:0] bc0_a, bc0_b;
  int na, nb;

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 1'b1, 1'b1, 32'hdead);
    #1 reset = 1'b1;
    #1 expect_ex_zero("reset_hold");
    tick();
    reset = 1'b0;

    // Pass-through
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 32'h10);
    #1 check("pass stall", {stall_a, stall_b}, 2'b00);
    tick();
    check("pass ex_rs", {ex_rs1_a, ex_rs2_a, ex_rd_a, ex_rs1_b, ex_rs2_b, ex_rd_b},
          {5'd3, 5'd4, 5'd5, 5'd3, 5'd4, 5'd5});
    check("pass ex_imm", {ex_imm_a, ex_imm_b}, {32'h10, 32'h10});
    check("pass ex_valid", {ex_valid_a, ex_valid_b}, 2'b11);
    check("pass stall after", {stall_a, stall_b}, 2'b00);

    // Reset mid-cycle with a full EX slot
    #1 reset = 1'b1;
    #1 expect_ex_zero("reset_async");
    tick();
    reset = 1'b0;

    // lw x5 ; add x6,x5,x1
    clear_pipe();
`ifdef HAZARD_STATS_EN
    bc0_a = bc_a; bc0_b = bc_b;
`endif
    set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h4);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 check("lu t0 stall", {stall_a, stall_b}, 2'b11);
    tick();
    check("lu t1 stall", {stall_a, stall_b}, 2'b01);
    check("lu t1 bubble", {ex_valid_a, ex_valid_b}, 2'b00);
    tick();
    check("lu1 add in EX", {ex_valid_a, ex_rs1_a}, {1'b1, 5'd5});
    check("lu3 t2", {stall_b, ex_valid_b}, 2'b10);
    tick();
    check("lu3 t3", {stall_b, ex_valid_b}, 2'b00);
    tick();
    check("lu3 add in EX", {ex_valid_b, ex_rs1_b}, {1'b1, 5'd5});
`ifdef HAZARD_STATS_EN
    check("lu bubbles", {bc_a - bc0_a, bc_b - bc0_b}, {32'd1, 32'd3});
`endif

    // lw x7 ; sub x8,x1,x7 -- count stall cycles
    clear_pipe();
`ifdef HAZARD_STATS_EN
    bc0_a = bc_a; bc0_b = bc_b;
`endif
    set_id(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h8);
    tick();
    set_id(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0);
    na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      na += int'(stall_a);
      nb += int'(stall_b);
      tick();
    end
    check("rs2 stall cycles", {na[7:0], nb[7:0]}, {8'd1, 8'd3});
    check("rs2 sub in EX", {ex_valid_b, ex_rs2_b, ex_rd_b}, {1'b1, 5'd7, 5'd8});
`ifdef HAZARD_STATS_EN
    check("rs2 bubbles", {bc_a - bc0_a, bc_b - bc0_b}, {32'd1, 32'd3});
`endif

    // No false stalls
    clear_pipe();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 check("x0 no stall", {stall_a, stall_b}, 2'b00);
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h0);
    #1 check("unused rs1 no stall", {stall_a, stall_b}, 2'b00);
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    set_id(1'b0, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 check("invalid no stall", {stall_a, stall_b}, 2'b00);
    tick();
    check("invalid bubble", {ex_valid_a, ex_valid_b}, 2'b00);

    // Flush in the hazard cycle
    clear_pipe();
`ifdef HAZARD_STATS_EN
    bc0_a = bc_a; bc0_b = bc_b;
`endif
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0);
    flush = 1'b1;
    #1 check("flush+hazard stall", {stall_a, stall_b}, 2'b00);
    tick();
    flush = 1'b0;
    check("flush bubble", {ex_valid_a, ex_valid_b}, 2'b00);
    #1 check("after flush stall", {stall_a, stall_b}, 2'b00);
`ifdef HAZARD_STATS_EN
    check("flush bubbles", {bc_a - bc0_a, bc_b - bc0_b}, 64'd0);
`endif

    // Flush in the second stall cycle
    clear_pipe();
`ifdef HAZARD_STATS_EN
    bc0_b = bc_b;
`endif
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 check("fs t0 stall", stall_b, 1'b1);
    tick();
    flush = 1'b1;
    #1 check("fs t1 stall", {stall_a, stall_b}, 2'b00);
    tick();
    flush = 1'b0;
    #1 check("fs t2", {stall_b, ex_valid_b}, 2'b00);
`ifdef HAZARD_STATS_EN
    check("fs bubbles", bc_b - bc0_b, 32'd1);
`endif
    tick();
    check("fs add in EX", {ex_valid_b, ex_rs1_b}, {1'b1, 5'd5});

    // Reset while stalling
    clear_pipe();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    #1 reset = 1'b1;
    #1 expect_ex_zero("reset_stall");
`ifdef HAZARD_STATS_EN
    check("reset_stall bubbles", {bc_a, bc_b}, 64'd0);
`endif
    tick();
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!(stall_a || stall_b) || $urandom_range(0, 1) == 0)
        set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               $urandom_range(0, 9) < 3, $urandom);
      flush = ($urandom_range(0, 11) == 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
